// File: rtl/tlc_pkg.sv
// Shared types and constants for the actuated traffic phase scheduler.
package tlc_pkg;

  localparam int TIMER_W = 7;

  typedef logic [1:0] side_idx_t;
  typedef logic [3:0] side_oh_t;

  typedef enum logic [3:0] {
    PH_IDLE    = 4'b0001,
    PH_ALL_RED = 4'b0010,
    PH_GREEN   = 4'b0100,
    PH_YELLOW  = 4'b1000
  } phase_t;

  function automatic side_oh_t side_to_oh(input side_idx_t s);
    return side_oh_t'(4'b0001 << s);
  endfunction

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// Detector/preempt inputs and signal-head outputs of the phase scheduler.
interface tlc_phase_scheduler_if;
  import tlc_pkg::*;

  logic                 start;
  side_oh_t             req;
  logic                 preempt;
  side_idx_t            preempt_side;
  side_oh_t             at_side;
  logic [3:0]           at_state;
  logic                 R;
  logic                 G;
  logic                 Y;
  logic [TIMER_W-1:0]   count;

  modport master (
    output start, req, preempt, preempt_side,
    input  at_side, at_state, R, G, Y, count
  );

  modport slave (
    input  start, req, preempt, preempt_side,
    output at_side, at_state, R, G, Y, count
  );

endinterface

// File: rtl/tlc_rr_arbiter.sv
// Picks the next side to serve: preempt side if requested, else first
// requesting side after ptr, else ptr+1.
module tlc_rr_arbiter
  import tlc_pkg::*;
(
  input  side_oh_t  req,
  input  side_idx_t ptr,
  input  logic      preempt,
  input  side_idx_t preempt_side,
  output side_idx_t next_side
);

  side_idx_t cand;

  always_comb begin
    next_side = ptr + 2'd1;
    cand      = '0;
    if (preempt) begin
      next_side = preempt_side;
    end else begin
      // Walk from farthest to nearest so the nearest requester wins.
      for (int i = 4; i >= 1; i--) begin
        cand = ptr + side_idx_t'(i);
        if (req[cand]) next_side = cand;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Actuated four-approach phase scheduler: green/yellow/all-red sequencing
// with round-robin side selection, min/max green and emergency preemption.
//
// state      | meaning
// PH_IDLE    | waiting for start, head red
// PH_ALL_RED | clearance, next side chosen on last cycle
// PH_GREEN   | serving side ptr
// PH_YELLOW  | change interval for side ptr
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int GREEN_MIN = 30,
  parameter int GREEN_MAX = 90,
  parameter int YELLOW    = 10,
  parameter int ALL_RED   = 2
) (
  input logic                  clk,
  input logic                  reset,
  tlc_phase_scheduler_if.slave bus
);

  localparam logic [TIMER_W-1:0] GMIN_TC = TIMER_W'(GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] GMAX_TC = TIMER_W'(GREEN_MAX - 1);
  localparam logic [TIMER_W-1:0] YEL_TC  = TIMER_W'(YELLOW - 1);
  localparam logic [TIMER_W-1:0] AR_TC   = TIMER_W'(ALL_RED - 1);

  phase_t             state, state_nxt;
  logic [TIMER_W-1:0] count_q;
  side_idx_t          ptr, arb_side;
  logic               other, green_exit;

  tlc_rr_arbiter u_arb (
    .req          (bus.req),
    .ptr          (ptr),
    .preempt      (bus.preempt),
    .preempt_side (bus.preempt_side),
    .next_side    (arb_side)
  );

  always_comb begin
    other      = |(bus.req & ~side_to_oh(ptr));
    green_exit = 1'b0;
    // Preempt on the current side pins green; on another side aborts it.
    if (bus.preempt)
      green_exit = (bus.preempt_side != ptr);
    else if (other)
      green_exit = (!bus.req[ptr] && (count_q >= GMIN_TC)) || (count_q == GMAX_TC);

    state_nxt = state;
    case (state)
      PH_IDLE:    if (bus.start)         state_nxt = PH_ALL_RED;
      PH_ALL_RED: if (count_q == AR_TC)  state_nxt = PH_GREEN;
      PH_GREEN:   if (green_exit)        state_nxt = PH_YELLOW;
      PH_YELLOW:  if (count_q == YEL_TC) state_nxt = PH_ALL_RED;
      default:                           state_nxt = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= PH_IDLE;
      count_q <= '0;
      ptr     <= 2'd3;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == PH_IDLE)
        count_q <= '0;
      else if (!(state == PH_GREEN && count_q == GMAX_TC))
        count_q <= count_q + TIMER_W'(1);
      if (state == PH_ALL_RED && state_nxt == PH_GREEN)
        ptr <= arb_side;
    end
  end

  assign bus.at_state = state;
  assign bus.at_side  = (state == PH_GREEN || state == PH_YELLOW) ? side_to_oh(ptr) : '0;
  assign bus.R        = (state == PH_IDLE) || (state == PH_ALL_RED);
  assign bus.G        = (state == PH_GREEN);
  assign bus.Y        = (state == PH_YELLOW);
  assign bus.count    = count_q;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed bench for tlc_phase_scheduler; completed phases are scored
// against a queue of expected (phase, side, length) records.
module tb_tlc_phase_scheduler;
  import tlc_pkg::*;

  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_AR   = 4'b0010;
  localparam logic [3:0] S_GRN  = 4'b0100;
  localparam logic [3:0] S_YEL  = 4'b1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   track = 1'b0;

  logic [23:0] exp_q[$];

  tlc_phase_scheduler_if bus ();

  tlc_phase_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void expect_phase(input logic [3:0] st, input logic [3:0] sd, input int n);
    exp_q.push_back({st, sd, 16'(n)});
  endfunction

  task automatic wait_for(input logic [3:0] st, input logic [3:0] sd, input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.at_state === st && bus.at_side === sd) && n < budget);
    chk(tag, {bus.at_state, bus.at_side}, {st, sd});
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Phase monitor: measures each phase in cycles and scores it on completion.
  initial begin
    logic [3:0] cur_st;
    logic [3:0] cur_sd;
    int len;
    logic [23:0] e;
    cur_st = S_IDLE;
    cur_sd = 4'b0000;
    len = 0;
    forever begin
      @(negedge clk);
      if (bus.at_state === cur_st && bus.at_side === cur_sd) begin
        len++;
      end else begin
        if (track && cur_st != S_IDLE) begin
          if (exp_q.size() == 0) begin
            chk("phase_unexpected", {8'h0, cur_st, cur_sd, 16'(len)}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("phase_record", {8'h0, cur_st, cur_sd, 16'(len)}, {8'h0, e});
          end
        end
        cur_st = bus.at_state;
        cur_sd = bus.at_side;
        len = 1;
      end
    end
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.req = 4'b0000;
    bus.preempt = 1'b0;
    bus.preempt_side = 2'd0;

    // 1: reset values, start with no requests, resting green on side 0
    apply_reset();
    chk("rst_state", bus.at_state, S_IDLE);
    chk("rst_side", bus.at_side, 4'b0000);
    chk("rst_lights", {bus.R, bus.G, bus.Y}, 3'b100);
    chk("rst_count", bus.count, 7'd0);
    track = 1'b1;
    expect_phase(S_AR, 4'b0000, 2);
    pulse_start();
    chk("t1_allred", bus.at_state, S_AR);
    wait_for(S_GRN, 4'b0001, 10, "t1_green0");
    repeat (120) @(negedge clk);
    chk("t1_rest_state", {bus.at_state, bus.at_side}, {S_GRN, 4'b0001});
    chk("t1_count_sat", bus.count, 7'd89);
    chk("t1_lights", {bus.R, bus.G, bus.Y}, 3'b010);
    chk("t1_queue", exp_q.size(), 0);
    track = 1'b0;

    // 2: req=0011 held -> max green on side 0, then side 1
    apply_reset();
    bus.req = 4'b0011;
    track = 1'b1;
    expect_phase(S_AR, 4'b0000, 2);
    expect_phase(S_GRN, 4'b0001, 90);
    expect_phase(S_YEL, 4'b0001, 10);
    expect_phase(S_AR, 4'b0000, 2);
    pulse_start();
    wait_for(S_GRN, 4'b0010, 200, "t2_next_side1");
    chk("t2_yellow_lights_off", {bus.R, bus.Y}, 2'b00);
    chk("t2_queue", exp_q.size(), 0);
    track = 1'b0;

    // 3: side 0 green, only side 2 requesting -> min green, side 1 skipped
    apply_reset();
    bus.req = 4'b0000;
    track = 1'b1;
    expect_phase(S_AR, 4'b0000, 2);
    expect_phase(S_GRN, 4'b0001, 30);
    expect_phase(S_YEL, 4'b0001, 10);
    expect_phase(S_AR, 4'b0000, 2);
    pulse_start();
    wait_for(S_GRN, 4'b0001, 10, "t3_green0");
    bus.req = 4'b0100;
    wait_for(S_GRN, 4'b0100, 100, "t3_next_side2");
    chk("t3_queue", exp_q.size(), 0);
    track = 1'b0;

    // 4: preemption abort at count 5, then preempt hold on the served side
    apply_reset();
    bus.req = 4'b0000;
    track = 1'b1;
    expect_phase(S_AR, 4'b0000, 2);
    pulse_start();
    wait_for(S_GRN, 4'b0001, 10, "t4_green0");
    repeat (5) @(negedge clk);
    chk("t4_count5", bus.count, 7'd5);
    bus.preempt = 1'b1;
    bus.preempt_side = 2'd3;
    expect_phase(S_GRN, 4'b0001, 6);
    expect_phase(S_YEL, 4'b0001, 10);
    expect_phase(S_AR, 4'b0000, 2);
    @(negedge clk);
    chk("t4_abort_yellow", bus.at_state, S_YEL);
    wait_for(S_GRN, 4'b1000, 30, "t4_preempt_side3");
    bus.req = 4'b1111;
    repeat (100) @(negedge clk);
    chk("t4_hold_green", {bus.at_state, bus.at_side}, {S_GRN, 4'b1000});
    chk("t4_hold_count", bus.count, 7'd89);
    bus.preempt = 1'b0;
    expect_phase(S_GRN, 4'b1000, 101);
    expect_phase(S_YEL, 4'b1000, 10);
    expect_phase(S_AR, 4'b0000, 2);
    @(negedge clk);
    chk("t4_release_yellow", bus.at_state, S_YEL);
    wait_for(S_GRN, 4'b0001, 30, "t4_wrap_side0");
    chk("t4_queue", exp_q.size(), 0);
    track = 1'b0;

    // 5: all sides requesting -> strict rotation with max green each
    apply_reset();
    bus.req = 4'b1111;
    track = 1'b1;
    expect_phase(S_AR, 4'b0000, 2);
    for (int s = 0; s < 4; s++) begin
      expect_phase(S_GRN, 4'(1 << s), 90);
      expect_phase(S_YEL, 4'(1 << s), 10);
      expect_phase(S_AR, 4'b0000, 2);
    end
    pulse_start();
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("t5_queue", exp_q.size(), 0);
    @(negedge clk);
    chk("t5_back_to_side0", {bus.at_state, bus.at_side}, {S_GRN, 4'b0001});
    track = 1'b0;

    // 6: reset during yellow, then no progress until a new start
    wait_for(S_YEL, 4'b0001, 200, "t6_yellow");
    reset = 1'b1;
    @(negedge clk);
    chk("t6_state", bus.at_state, S_IDLE);
    chk("t6_side", bus.at_side, 4'b0000);
    chk("t6_lights", {bus.R, bus.G, bus.Y}, 3'b100);
    chk("t6_count", bus.count, 7'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_still_idle", {bus.at_state, 3'b000, bus.count}, {S_IDLE, 10'd0});
    pulse_start();
    chk("t6_restart", bus.at_state, S_AR);
    wait_for(S_GRN, 4'b0001, 10, "t6_restart_side0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlc_phase_scheduler.md
# tlc_phase_scheduler

Actuated phase scheduler for a four-approach intersection. It sequences the single signal head through green, yellow and all-red phases and decides which side is served next. Side selection is round-robin over the vehicle-detector requests, with min/max green timing and emergency preemption. It sits in the traffic-light top level in place of the fixed-time controller/counter/comparator trio and owns its phase timer internally.

## Interface
- `GREEN_MIN`, default 30: minimum green length, in cycles.
- `GREEN_MAX`, default 90: maximum green length when another side is waiting, in cycles.
- `YELLOW`, default 10: yellow length, in cycles.
- `ALL_RED`, default 2: all-red clearance length, in cycles.
- Parameter constraint: 1 ≤ each parameter ≤ 127, and GREEN_MIN ≤ GREEN_MAX.

- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: leave IDLE; sampled only in IDLE.
- `req` in 4: per-side vehicle-detect levels; bit i = side i.
- `preempt` in 1: emergency request, level.
- `preempt_side` in 2: side index to serve under preemption.
- `at_side` out 4: one-hot current side in GREEN/YELLOW; 0000 otherwise.
- `at_state` out 4: one-hot phase (IDLE=0001, ALL_RED=0010, GREEN=0100, YELLOW=1000).
- `R`, `G`, `Y` out 1 each: light outputs for the served side.
- `count` out 7: phase timer, for debug and bench visibility.

## Operation
- **Reset values:** state IDLE; at_state=0001; at_side=0000; R=1, G=0, Y=0; count=0; side pointer `ptr`=3.
- **Phase timer (`count`):** cleared on every phase entry; increments once per cycle; saturates at GREEN_MAX-1 in GREEN.
- **IDLE:** hold with R=1. `start`=1 → ALL_RED.
- **ALL_RED:** R=1, at_side=0000. Lasts exactly ALL_RED cycles. At count==ALL_RED-1, select the next side and go GREEN:
  - If `preempt`=1, the next side is `preempt_side`.
  - Otherwise, the next side is the first requesting side in the order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - If no side is requesting, the next side is ptr+1.
  - `ptr` is updated to the selected side.
- **GREEN:** G=1. Define `other` = any req bit set other than the current side. Exit to YELLOW on the first cycle where either:
  - `other` && !req[cur] && count ≥ GREEN_MIN-1; or
  - `other` && count == GREEN_MAX-1.

  With no `other`, green rests indefinitely and count holds at GREEN_MAX-1.
- **YELLOW:** Y=1. Lasts exactly YELLOW cycles, then ALL_RED.
- **Preemption:**
  - `preempt`=1 in GREEN with preempt_side≠cur → YELLOW on the next edge; GREEN_MIN is ignored.
  - `preempt`=1 with preempt_side==cur → all GREEN exits are suppressed while `preempt` stays high.
  - `preempt` asserted during YELLOW/ALL_RED → that phase completes at normal length; the side selection that follows picks preempt_side.
  - `preempt` dropping during the preempted green → normal exit rules resume on the following cycle, using the current count.
- **Simultaneous events:** `reset` dominates everything. `start` is ignored outside IDLE. Changes to `req` mid-phase only affect GREEN exit and the next selection.
- **Reset mid-operation:** next edge returns to the reset values; a new `start` is required.

## Timing
- All outputs are decoded from registered state and `count`; no combinational path from any input to any output.
- Condition sampled true at edge k → new phase visible after edge k (same edge).
- `start` high at edge n → ALL_RED after n → GREEN after n+ALL_RED.
- Phase lengths in cycles:
  - GREEN: ≥ GREEN_MIN; ≤ GREEN_MAX when another side is requesting; 1 at minimum under a preemption abort.
  - YELLOW: exactly YELLOW.
  - ALL_RED: exactly ALL_RED.
- A full side change (yellow + all-red) costs YELLOW+ALL_RED = 12 cycles at defaults.

## Structure
- Package `tlc_pkg`:
  - phase one-hot encodings;
  - side index type (2 bits) and one-hot side type (4 bits);
  - timer width constant (7).
- Sub-module `tlc_rr_arbiter`: combinational round-robin picker. Inputs: req, ptr, preempt, preempt_side. Output: next side. Unit-testable on its own.
- Top level holds the state register, timer, `ptr` and the output decode.

## Test plan
1. Reset, then `start` pulse with req=0000 → ALL_RED 2 cycles, then GREEN with at_side=0001; it stays green with count saturated at 89.
2. Side 0 green, req=0011 held → green 90 cycles, YELLOW 10, ALL_RED 2, then at_side=0010.
3. Side 0 green, req=0100 held → green exactly 30 cycles; next side 2 (side 1 skipped).
4. Side 0 green, count=5, preempt=1 with preempt_side=3 → YELLOW on the next edge, then 10+2 cycles, then at_side=1000. With req=1111, green holds beyond 90 cycles until preempt=0.
5. req=1111 held from start → sides served in order 0,1,2,3,0, each green exactly 90 cycles.
6. reset asserted mid-YELLOW → next edge: at_state=0001, at_side=0000, R=1, count=0; no progress until `start` is asserted again.
